// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse decoder slice.
//   SYM_W    : maximum number of symbols in one letter (pattern width)
//   CNT_W    : width of the symbol counter (0..SYM_W)
//   DUR_W    : width of the saturating tick-duration counter
//   ASCII_A  : ASCII code of 'A', base for letter lookup
//   ASCII_0  : ASCII code of '0', base for digit lookup
//   state_t  : decoder FSM states
//   lut_out_t: lookup result {valid, ascii}
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int SYM_W = 5;
  localparam int CNT_W = 3;
  localparam int DUR_W = 8;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_0 = 8'h30;

  typedef enum logic [2:0] {
    ST_WAIT_REL,
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_DECODE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } lut_out_t;

endpackage

// File: rtl/morse_decoder_if.sv
// -----------------------------------------------------------------------------
// morse_decoder_if
// Key input and decoded-letter outputs of the Morse decoder.
//   key_in    : raw Morse key, high = pressed (asynchronous to clk)
//   letter    : last valid decoded ASCII code
//   send      : sticky flag, high once any valid letter was decoded
//   done      : one-cycle pulse when letter updates
//   err       : one-cycle pulse on an invalid or overlong pattern
//   sym_count : symbols accumulated in the current letter
// Modports: master drives the key and consumes letters; slave is the decoder.
// -----------------------------------------------------------------------------
interface morse_decoder_if;
  import morse_pkg::*;

  logic             key_in;
  logic [7:0]       letter;
  logic             send;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] sym_count;

  modport master (
    output key_in,
    input  letter, send, done, err, sym_count
  );

  modport slave (
    input  key_in,
    output letter, send, done, err, sym_count
  );

endinterface

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational Morse pattern lookup. The pattern holds the first symbol in
// its most significant used bit (symbols are shifted in at the LSB);
// 1 = dash, 0 = dot.
//   sym_count : number of valid symbols in pattern (1..5)
//   pattern   : symbol bits, only the low sym_count bits are used
//   result    : {valid, ascii}
// Build option: define MORSE_DIGITS_EN to decode 5-symbol patterns to '0'-'9';
// without it every 5-symbol pattern is invalid.
// -----------------------------------------------------------------------------
module morse_lut
  import morse_pkg::*;
(
  input  logic [CNT_W-1:0] sym_count,
  input  logic [SYM_W-1:0] pattern,
  output lut_out_t         result
);

  logic [4:0] letter_idx;  // 0 = 'A' .. 25 = 'Z'
  logic [3:0] digit;
  logic       is_letter;
  logic       is_digit;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    letter_idx = '0;
    digit      = '0;
    is_letter  = 1'b0;
    is_digit   = 1'b0;

    case (sym_count)
      3'd1: begin
        is_letter  = 1'b1;
        letter_idx = pattern[0] ? 5'd19 : 5'd4;             // T : E
      end
      3'd2: begin
        is_letter = 1'b1;
        case (pattern[1:0])
          2'b00:   letter_idx = 5'd8;                       // I
          2'b01:   letter_idx = 5'd0;                       // A
          2'b10:   letter_idx = 5'd13;                      // N
          default: letter_idx = 5'd12;                      // M
        endcase
      end
      3'd3: begin
        is_letter = 1'b1;
        case (pattern[2:0])
          3'b000:  letter_idx = 5'd18;                      // S
          3'b001:  letter_idx = 5'd20;                      // U
          3'b010:  letter_idx = 5'd17;                      // R
          3'b011:  letter_idx = 5'd22;                      // W
          3'b100:  letter_idx = 5'd3;                       // D
          3'b101:  letter_idx = 5'd10;                      // K
          3'b110:  letter_idx = 5'd6;                       // G
          default: letter_idx = 5'd14;                      // O
        endcase
      end
      3'd4: begin
        is_letter = 1'b1;
        case (pattern[3:0])
          4'b0000: letter_idx = 5'd7;                       // H
          4'b0001: letter_idx = 5'd21;                      // V
          4'b0010: letter_idx = 5'd5;                       // F
          4'b0100: letter_idx = 5'd11;                      // L
          4'b0110: letter_idx = 5'd15;                      // P
          4'b0111: letter_idx = 5'd9;                       // J
          4'b1000: letter_idx = 5'd1;                       // B
          4'b1001: letter_idx = 5'd23;                      // X
          4'b1010: letter_idx = 5'd2;                       // C
          4'b1011: letter_idx = 5'd24;                      // Y
          4'b1100: letter_idx = 5'd25;                      // Z
          4'b1101: letter_idx = 5'd16;                      // Q
          default: is_letter  = 1'b0;                       // ..--, .-.-, ---., ----
        endcase
      end
`ifdef MORSE_DIGITS_EN
      3'd5: begin
        is_digit = 1'b1;
        case (pattern)
          5'b11111: digit = 4'd0;
          5'b01111: digit = 4'd1;
          5'b00111: digit = 4'd2;
          5'b00011: digit = 4'd3;
          5'b00001: digit = 4'd4;
          5'b00000: digit = 4'd5;
          5'b10000: digit = 4'd6;
          5'b11000: digit = 4'd7;
          5'b11100: digit = 4'd8;
          5'b11110: digit = 4'd9;
          default:  is_digit = 1'b0;
        endcase
      end
`else
      3'd5: begin
        is_digit = 1'b0;
      end
`endif
      default: begin
        is_letter = 1'b0;
      end
    endcase
  end

  always_comb begin
    result.valid = is_letter | is_digit;
    result.ascii = is_digit ? (ASCII_0 + {4'b0000, digit})
                            : (ASCII_A + {3'b000, letter_idx});
  end

endmodule

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Times Morse key presses and gaps with a prescaled tick, classifies presses
// as dot/dash, accumulates up to SYM_W symbols and decodes a letter after a
// long gap.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : morse_decoder_if.slave (key_in in; letter/send/done/err/sym_count out)
// Parameters (all in ticks except TICK_DIV, which is clock cycles per tick):
//   TICK_DIV, MIN_PRESS (glitch reject), DOT_MAX (dot/dash split),
//   LETTER_GAP (end-of-letter release length).
// Build option MORSE_DIGITS_EN (see morse_lut) enables digit decoding.
// -----------------------------------------------------------------------------
module morse_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 1_000_000,
  parameter int MIN_PRESS  = 2,
  parameter int DOT_MAX    = 20,
  parameter int LETTER_GAP = 40
) (
  input logic            clk,
  input logic            reset,
  morse_decoder_if.slave bus
);

  localparam int               PRE_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX      = '1;
  localparam logic [DUR_W-1:0] MIN_PRESS_D  = DUR_W'(MIN_PRESS);
  localparam logic [DUR_W-1:0] DOT_MAX_D    = DUR_W'(DOT_MAX);
  localparam logic [DUR_W-1:0] LETTER_GAP_D = DUR_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] SYM_FULL     = CNT_W'(SYM_W);

  // Synchronizer, edge detect and a fill marker that tells WAIT_REL when the
  // synchronized level reflects the real key rather than reset zeros.
  logic       key_s1, key_s2, key_d;
  logic [1:0] sync_vld;
  logic       key_rise, key_fall, key_edge;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] gap_save_q;   // gap length at the rising edge, restored on a glitch
  logic             from_gap_q;   // PRESS was entered from GAP

  state_t           state_q, state_d;
  logic             restore_gap, push_sym;
  logic [SYM_W-1:0] pattern_q;
  logic [CNT_W-1:0] sym_cnt_q;
  logic             ovf_q;
  lut_out_t         lut_res;

  logic [7:0] letter_q;
  logic       send_q, done_q, err_q;

  assign key_rise = key_s2 & ~key_d;
  assign key_fall = ~key_s2 & key_d;
  assign key_edge = key_rise | key_fall;
  assign tick     = (pre_cnt == PRE_LAST);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1   <= 1'b0;
      key_s2   <= 1'b0;
      key_d    <= 1'b0;
      sync_vld <= '0;
      pre_cnt  <= '0;
    end else begin
      key_s1   <= bus.key_in;
      key_s2   <= key_s1;
      key_d    <= key_s2;
      sync_vld <= {sync_vld[0], 1'b1};
      pre_cnt  <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Duration counter: a glitch restore wins, then any edge clears, then a
  // tick advances (saturating).
  always_ff @(posedge clk) begin
    if (reset) begin
      dur_q <= '0;
    end else if (restore_gap) begin
      dur_q <= gap_save_q;
    end else if (key_edge) begin
      dur_q <= '0;
    end else if (tick && dur_q != DUR_MAX) begin
      dur_q <= dur_q + DUR_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    restore_gap = 1'b0;
    push_sym    = 1'b0;
    case (state_q)
      ST_WAIT_REL: if (sync_vld[1] && !key_s2) state_d = ST_IDLE;
      ST_IDLE:     if (key_rise) state_d = ST_PRESS;
      ST_PRESS: begin
        if (key_fall) begin
          if (dur_q < MIN_PRESS_D) begin
            state_d     = from_gap_q ? ST_GAP : ST_IDLE;
            restore_gap = from_gap_q;
          end else begin
            push_sym = 1'b1;
            state_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (key_rise)                   state_d = ST_PRESS;
        else if (dur_q >= LETTER_GAP_D) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_IDLE;
      default:   state_d = ST_WAIT_REL;
    endcase
  end

  morse_lut u_lut (
    .sym_count (sym_cnt_q),
    .pattern   (pattern_q),
    .result    (lut_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT_REL;
      pattern_q  <= '0;
      sym_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      from_gap_q <= 1'b0;
      gap_save_q <= '0;
      letter_q   <= 8'h00;
      send_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;

      if ((state_q == ST_IDLE || state_q == ST_GAP) && key_rise) begin
        from_gap_q <= (state_q == ST_GAP);
        gap_save_q <= dur_q;
      end

      if (push_sym) begin
        if (sym_cnt_q == SYM_FULL) begin
          ovf_q <= 1'b1;
        end else begin
          pattern_q <= {pattern_q[SYM_W-2:0], (dur_q > DOT_MAX_D)};
          sym_cnt_q <= sym_cnt_q + CNT_W'(1);
        end
      end

      if (state_q == ST_DECODE) begin
        if (lut_res.valid && !ovf_q) begin
          letter_q <= lut_res.ascii;
          done_q   <= 1'b1;
          send_q   <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
        pattern_q <= '0;
        sym_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end
    end
  end

  assign bus.letter    = letter_q;
  assign bus.send      = send_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sym_count = sym_cnt_q;

endmodule

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
// Scoreboard bench for morse_decoder with TICK_DIV=4, MIN_PRESS=1, DOT_MAX=3,
// LETTER_GAP=6. Expected letter/err events are queued when a letter is keyed
// and popped by a negedge monitor whenever done or err pulses. Key changes
// are placed at a known prescaler phase so press durations land exactly.
// -----------------------------------------------------------------------------
module tb_morse_decoder;
  import morse_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int MIN_PRESS  = 1;
  localparam int DOT_MAX    = 3;
  localparam int LETTER_GAP = 6;
  localparam int DOT_T      = 2;
  localparam int DASH_T     = 5;
  localparam int SYM_GAP_T  = 2;
  localparam int LET_GAP_T  = 8;

  typedef struct packed {
    logic       is_err;
    logic [7:0] letter;
    logic       send;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;      // cycles since reset release; equals prescaler count mod 4
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_pulse = 1'b0;
  logic [7:0] exp_letter = 8'h00;
  logic       exp_send   = 1'b0;

  morse_decoder_if bus ();

  morse_decoder #(
    .TICK_DIV   (TICK_DIV),
    .MIN_PRESS  (MIN_PRESS),
    .DOT_MAX    (DOT_MAX),
    .LETTER_GAP (LETTER_GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Event monitor: every done/err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (bus.done || bus.err)) begin
      check("pulse_width", {31'b0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'b0, bus.done, bus.err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_err",  {31'b0, bus.err},  {31'b0, mon_e.is_err});
        check("event_done", {31'b0, bus.done}, {31'b0, ~mon_e.is_err});
        check("letter",     {24'b0, bus.letter}, {24'b0, mon_e.letter});
        check("send",       {31'b0, bus.send}, {31'b0, mon_e.send});
      end
    end
    prev_pulse <= !reset && (bus.done || bus.err);
  end

  task automatic tick_wait(input int n);
    repeat (TICK_DIV * n) @(negedge clk);
  endtask

  task automatic align(input int phase);
    while (cyc % TICK_DIV != phase) @(negedge clk);
  endtask

  task automatic key_sym(input int hi, input int lo);
    align(0);
    bus.key_in = 1'b1;
    tick_wait(hi);
    bus.key_in = 1'b0;
    tick_wait(lo);
  endtask

  task automatic key_letter(input string code);
    for (int i = 0; i < code.len(); i++)
      key_sym((code[i] == "-") ? DASH_T : DOT_T,
              (i == code.len() - 1) ? LET_GAP_T : SYM_GAP_T);
  endtask

  task automatic expect_letter(input logic [7:0] l);
    exp_letter = l;
    exp_send   = 1'b1;
    exp_q.push_back('{is_err: 1'b0, letter: l, send: 1'b1});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, letter: exp_letter, send: exp_send});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.key_in = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_letter",    {24'b0, bus.letter},   32'h00);
    check("rst_send",      {31'b0, bus.send},     32'd0);
    check("rst_done",      {31'b0, bus.done},     32'd0);
    check("rst_err",       {31'b0, bus.err},      32'd0);
    check("rst_sym_count", {29'b0, bus.sym_count}, 32'd0);
    tick_wait(2);

    // 'A': 2-tick press, 2-tick gap, 5-tick press, long gap
    expect_letter(8'h41);
    key_sym(2, 2);
    key_sym(5, 8);
    drain("drain_A");
    check("A_sym_count", {29'b0, bus.sym_count}, 32'd0);
    check("A_send",      {31'b0, bus.send},      32'd1);

    // SOS
    expect_letter(8'h53);
    key_letter("...");
    expect_letter(8'h4F);
    key_letter("---");
    expect_letter(8'h53);
    key_letter("...");
    drain("drain_SOS");

    // 2-cycle blip at a phase where no tick falls inside: rejected as glitch
    align(2);
    bus.key_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.key_in = 1'b0;
    tick_wait(10);
    check("blip_sym_count", {29'b0, bus.sym_count}, 32'd0);
    check("blip_letter",    {24'b0, bus.letter},    32'h53);

    // Six dots: overflow -> err, letter and send unchanged
    expect_err();
    key_letter("......");
    drain("drain_ovf");
    check("ovf_letter", {24'b0, bus.letter}, 32'h53);
    check("ovf_send",   {31'b0, bus.send},   32'd1);

    // Five dashes: digit '0' or err depending on build
`ifdef MORSE_DIGITS_EN
    expect_letter(8'h30);
`else
    expect_err();
`endif
    for (int i = 0; i < 3; i++) key_sym(DASH_T, SYM_GAP_T);
    check("mid_sym_count", {29'b0, bus.sym_count}, 32'd3);
    key_sym(DASH_T, SYM_GAP_T);
    key_sym(DASH_T, LET_GAP_T);
    drain("drain_five_dash");
    check("five_dash_sym_count", {29'b0, bus.sym_count}, 32'd0);

    // Reset during a second press with the key held
    key_sym(DOT_T, SYM_GAP_T);
    align(0);
    bus.key_in = 1'b1;
    tick_wait(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_letter = 8'h00;
    exp_send   = 1'b0;
    check("mid_rst_letter",    {24'b0, bus.letter},    32'h00);
    check("mid_rst_send",      {31'b0, bus.send},      32'd0);
    check("mid_rst_done",      {31'b0, bus.done},      32'd0);
    check("mid_rst_err",       {31'b0, bus.err},       32'd0);
    check("mid_rst_sym_count", {29'b0, bus.sym_count}, 32'd0);
    tick_wait(3);
    check("held_sym_count", {29'b0, bus.sym_count}, 32'd0);
    align(0);
    bus.key_in = 1'b0;
    tick_wait(3);
    check("released_sym_count", {29'b0, bus.sym_count}, 32'd0);
    expect_letter(8'h45);
    key_sym(DOT_T, LET_GAP_T);
    drain("drain_E");
    check("E_letter", {24'b0, bus.letter}, 32'h45);
    check("E_send",   {31'b0, bus.send},   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
